// File: rtl/multi_cycle_cu_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, funcs, FSM states,
// mux selects and the instruction classes produced by cu_decode.
package multi_cycle_cu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_BGTZ  = 6'b000111;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   localparam logic [2:0] S_IF   = 3'b000;
   localparam logic [2:0] S_ID   = 3'b001;
   localparam logic [2:0] S_EXE  = 3'b010;
   localparam logic [2:0] S_MEM  = 3'b011;
   localparam logic [2:0] S_WB   = 3'b100;
   localparam logic [2:0] S_HALT = 3'b101;

   localparam logic [1:0] PC_NEXT = 2'b00;
   localparam logic [1:0] PC_REL  = 2'b01;
   localparam logic [1:0] PC_ABS  = 2'b10;
   localparam logic [1:0] PC_REG  = 2'b11;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;
   localparam logic [2:0] ALU_SLL  = 3'b100;
   localparam logic [2:0] ALU_CMPS = 3'b101;

   localparam logic [1:0] DST_R31 = 2'b00;
   localparam logic [1:0] DST_RT  = 2'b01;
   localparam logic [1:0] DST_RD  = 2'b10;

   localparam logic [1:0] WD_ALU = 2'b00;
   localparam logic [1:0] WD_DM  = 2'b01;
   localparam logic [1:0] WD_PC4 = 2'b10;

   typedef enum logic [3:0] {
      CL_ALU_R,
      CL_JR,
      CL_ALU_I,
      CL_LW,
      CL_SW,
      CL_BEQ,
      CL_BNE,
      CL_BGTZ,
      CL_J,
      CL_JAL,
      CL_HALT,
      CL_ILLEGAL
   } inst_class_e;

endpackage

// File: rtl/multi_cycle_cu_decode.sv
// Combinational classifier: Op/Func to instruction class plus the ALU-side controls
// that the FSM drives during sEXE.
module cu_decode
   import multi_cycle_cu_pkg::*;
#(
   parameter int OP_W    = 6,
   parameter int FUNC_W  = 6,
   parameter int ALUOP_W = 3
) (
   input  logic [OP_W-1:0]    op_i,
   input  logic [FUNC_W-1:0]  func_i,
   output inst_class_e        cls_o,
   output logic [ALUOP_W-1:0] alu_op_o,
   output logic               alu_src_a_o,
   output logic               alu_src_b_o,
   output logic               ext_sel_o
);

   logic [5:0] op6;
   logic [5:0] fn6;
   logic [2:0] alu;

   assign op6      = 6'(op_i);
   assign fn6      = 6'(func_i);
   assign alu_op_o = ALUOP_W'(alu);

   always_comb begin
      cls_o       = CL_ILLEGAL;
      alu         = ALU_ADD;
      alu_src_a_o = 1'b0;
      alu_src_b_o = 1'b0;
      ext_sel_o   = 1'b0;
      case (op6)
         OP_RTYPE: begin
            case (fn6)
               FN_ADD: cls_o = CL_ALU_R;
               FN_SUB: begin cls_o = CL_ALU_R; alu = ALU_SUB;  end
               FN_AND: begin cls_o = CL_ALU_R; alu = ALU_AND;  end
               FN_OR:  begin cls_o = CL_ALU_R; alu = ALU_OR;   end
               FN_SLT: begin cls_o = CL_ALU_R; alu = ALU_CMPS; end
               // Shift amount comes from the SA field, not rs
               FN_SLL: begin cls_o = CL_ALU_R; alu = ALU_SLL; alu_src_a_o = 1'b1; end
               FN_JR:  cls_o = CL_JR;
               default: cls_o = CL_ILLEGAL;
            endcase
         end
         OP_ADDI: begin cls_o = CL_ALU_I; alu_src_b_o = 1'b1; ext_sel_o = 1'b1; end
         OP_ORI:  begin cls_o = CL_ALU_I; alu = ALU_OR; alu_src_b_o = 1'b1; end
         OP_LW:   begin cls_o = CL_LW;    alu_src_b_o = 1'b1; ext_sel_o = 1'b1; end
         OP_SW:   begin cls_o = CL_SW;    alu_src_b_o = 1'b1; ext_sel_o = 1'b1; end
         OP_BEQ:  begin cls_o = CL_BEQ;   alu = ALU_SUB; ext_sel_o = 1'b1; end
         OP_BNE:  begin cls_o = CL_BNE;   alu = ALU_SUB; ext_sel_o = 1'b1; end
         OP_BGTZ: begin cls_o = CL_BGTZ;  alu = ALU_SUB; ext_sel_o = 1'b1; end
         OP_J:    cls_o = CL_J;
         OP_JAL:  cls_o = CL_JAL;
         OP_HALT: cls_o = CL_HALT;
         default: cls_o = CL_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/multi_cycle_cu.sv
// Multi-cycle control FSM (IF/ID/EXE/MEM/WB/HALT) with memory-ready stalls and a
// retired-instruction counter; all outputs are combinational from state and inputs.
module multi_cycle_cu
   import multi_cycle_cu_pkg::*;
#(
   parameter int OP_W    = 6,
   parameter int FUNC_W  = 6,
   parameter int ALUOP_W = 3,
   parameter int CNT_W   = 32
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic [OP_W-1:0]    Op,
   input  logic [FUNC_W-1:0]  Func,
   input  logic               ZERO,
   input  logic               SIGN,
   input  logic               MemReady,
   output logic               PCWre,
   output logic               IRWre,
   output logic [1:0]         PCSrc,
   output logic               ALUSrcA,
   output logic               ALUSrcB,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               ExtSel,
   output logic               RegWr,
   output logic [1:0]         RegDst,
   output logic [1:0]         WrDataSrc,
   output logic               nRD,
   output logic               nWR,
   output logic               Halted,
   output logic               IllegalOp,
   output logic [CNT_W-1:0]   InstRetired
);

   logic [2:0]         state_q, state_d, st;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   inst_class_e        cls;
   logic [ALUOP_W-1:0] dec_alu_op;
   logic               dec_src_a, dec_src_b, dec_ext;

   cu_decode #(
      .OP_W    (OP_W),
      .FUNC_W  (FUNC_W),
      .ALUOP_W (ALUOP_W)
   ) u_decode (
      .op_i        (Op),
      .func_i      (Func),
      .cls_o       (cls),
      .alu_op_o    (dec_alu_op),
      .alu_src_a_o (dec_src_a),
      .alu_src_b_o (dec_src_b),
      .ext_sel_o   (dec_ext)
   );

   always_comb begin
      // While reset is held the outputs already look like sIF, so no strobe leaks out
      st        = nRST ? state_q : S_IF;
      state_d   = S_IF;
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      PCSrc     = PC_NEXT;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 1'b0;
      ALUOp     = '0;
      ExtSel    = 1'b0;
      RegWr     = 1'b0;
      RegDst    = DST_R31;
      WrDataSrc = WD_ALU;
      nRD       = 1'b1;
      nWR       = 1'b1;
      Halted    = 1'b0;
      IllegalOp = 1'b0;
      case (st)
         S_IF: begin
            IRWre   = MemReady;
            state_d = MemReady ? S_ID : S_IF;
         end
         S_ID: begin
            case (cls)
               CL_J: begin
                  PCWre = 1'b1;
                  PCSrc = PC_ABS;
               end
               CL_JAL: begin
                  PCWre     = 1'b1;
                  PCSrc     = PC_ABS;
                  RegWr     = 1'b1;
                  RegDst    = DST_R31;
                  WrDataSrc = WD_PC4;
               end
               CL_JR: begin
                  PCWre = 1'b1;
                  PCSrc = PC_REG;
               end
               CL_HALT: state_d = S_HALT;
               CL_ILLEGAL: begin
                  IllegalOp = 1'b1;
                  PCWre     = 1'b1;
               end
               default: state_d = S_EXE;
            endcase
         end
         S_EXE: begin
            ALUOp   = dec_alu_op;
            ALUSrcA = dec_src_a;
            ALUSrcB = dec_src_b;
            ExtSel  = dec_ext;
            case (cls)
               CL_BEQ: begin
                  PCWre = 1'b1;
                  PCSrc = ZERO ? PC_REL : PC_NEXT;
               end
               CL_BNE: begin
                  PCWre = 1'b1;
                  PCSrc = !ZERO ? PC_REL : PC_NEXT;
               end
               CL_BGTZ: begin
                  PCWre = 1'b1;
                  PCSrc = (!SIGN && !ZERO) ? PC_REL : PC_NEXT;
               end
               CL_LW, CL_SW: state_d = S_MEM;
               default:      state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (cls == CL_LW) begin
               nRD     = 1'b0;
               state_d = MemReady ? S_WB : S_MEM;
            end else if (cls == CL_SW) begin
               nWR     = 1'b0;
               PCWre   = MemReady;
               state_d = MemReady ? S_IF : S_MEM;
            end
         end
         S_WB: begin
            RegWr = 1'b1;
            PCWre = 1'b1;
            case (cls)
               CL_LW: begin
                  RegDst    = DST_RT;
                  WrDataSrc = WD_DM;
               end
               CL_ALU_I: RegDst = DST_RT;
               default:  RegDst = DST_RD;
            endcase
         end
         S_HALT: begin
            Halted  = 1'b1;
            state_d = S_HALT;
         end
         default: state_d = S_IF;
      endcase
   end

   assign cnt_d       = PCWre ? cnt_q + CNT_W'(1) : cnt_q;
   assign InstRetired = cnt_q;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= S_IF;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_multi_cycle_cu.sv
// Directed bench for multi_cycle_cu: walks each instruction class through its states
// with hand-computed expected control values; counter narrowed to 4 bits to show wrap.
module tb_multi_cycle_cu;

   logic       CLK;
   logic       nRST;
   logic [5:0] Op;
   logic [5:0] Func;
   logic       ZERO, SIGN, MemReady;
   logic       PCWre, IRWre, ALUSrcA, ALUSrcB, ExtSel, RegWr;
   logic [1:0] PCSrc, RegDst, WrDataSrc;
   logic [2:0] ALUOp;
   logic       nRD, nWR, Halted, IllegalOp;
   logic [3:0] InstRetired;

   int n_chk = 0;
   int n_err = 0;

   multi_cycle_cu #(
      .OP_W    (6),
      .FUNC_W  (6),
      .ALUOP_W (3),
      .CNT_W   (4)
   ) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .Op          (Op),
      .Func        (Func),
      .ZERO        (ZERO),
      .SIGN        (SIGN),
      .MemReady    (MemReady),
      .PCWre       (PCWre),
      .IRWre       (IRWre),
      .PCSrc       (PCSrc),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .ALUOp       (ALUOp),
      .ExtSel      (ExtSel),
      .RegWr       (RegWr),
      .RegDst      (RegDst),
      .WrDataSrc   (WrDataSrc),
      .nRD         (nRD),
      .nWR         (nWR),
      .Halted      (Halted),
      .IllegalOp   (IllegalOp),
      .InstRetired (InstRetired)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge and land mid-cycle, away from the clock edges
   task automatic cyc();
      @(posedge CLK);
      #3;
   endtask

   initial begin
      nRST = 1'b0; MemReady = 1'b1; Op = 6'b000000; Func = 6'b000000;
      ZERO = 1'b0; SIGN = 1'b0;
      cyc(); cyc();
      chk("rst_cnt", InstRetired, 0);
      chk("rst_nwr", nWR, 1);
      chk("rst_nrd", nRD, 1);
      chk("rst_pcwre", PCWre, 0);
      nRST = 1'b1;

      // ADD, with one fetch wait cycle in sIF
      Op = 6'b000000; Func = 6'b100000; MemReady = 1'b0;
      #1 chk("if_wait_irwre", IRWre, 0);
      cyc();
      MemReady = 1'b1;
      #1 chk("if_irwre", IRWre, 1);
      chk("if_pcwre", PCWre, 0);
      cyc();
      chk("add_id_pcwre", PCWre, 0);
      chk("add_id_regwr", RegWr, 0);
      chk("add_id_irwre", IRWre, 0);
      cyc();
      chk("add_exe_aluop", ALUOp, 3'b000);
      chk("add_exe_srcb", ALUSrcB, 0);
      chk("add_exe_regwr", RegWr, 0);
      chk("add_exe_pcwre", PCWre, 0);
      cyc();
      chk("add_wb_regwr", RegWr, 1);
      chk("add_wb_regdst", RegDst, 2'b10);
      chk("add_wb_pcwre", PCWre, 1);
      chk("add_wb_pcsrc", PCSrc, 2'b00);
      chk("add_wb_cnt", InstRetired, 0);
      cyc();
      chk("add_ret_cnt", InstRetired, 1);
      chk("add_ret_irwre", IRWre, 1);

      // LW with two data-memory wait cycles
      Op = 6'b100011;
      cyc();
      cyc();
      chk("lw_exe_srcb", ALUSrcB, 1);
      chk("lw_exe_ext", ExtSel, 1);
      chk("lw_exe_aluop", ALUOp, 3'b000);
      chk("lw_exe_nrd", nRD, 1);
      MemReady = 1'b0;
      cyc();
      chk("lw_mem1_nrd", nRD, 0);
      cyc();
      chk("lw_mem2_nrd", nRD, 0);
      chk("lw_mem2_pcwre", PCWre, 0);
      cyc();
      MemReady = 1'b1;
      #1 chk("lw_mem3_nrd", nRD, 0);
      chk("lw_mem3_pcwre", PCWre, 0);
      cyc();
      chk("lw_wb_regwr", RegWr, 1);
      chk("lw_wb_regdst", RegDst, 2'b01);
      chk("lw_wb_wrsrc", WrDataSrc, 2'b01);
      chk("lw_wb_nrd", nRD, 1);
      chk("lw_wb_pcwre", PCWre, 1);
      cyc();
      chk("lw_ret_cnt", InstRetired, 2);

      // BNE taken, BNE not taken
      Op = 6'b000101; ZERO = 1'b0;
      cyc(); cyc();
      chk("bne_t_pcsrc", PCSrc, 2'b01);
      chk("bne_t_pcwre", PCWre, 1);
      chk("bne_t_aluop", ALUOp, 3'b001);
      cyc();
      chk("bne_t_cnt", InstRetired, 3);
      chk("bne_t_irwre", IRWre, 1);
      ZERO = 1'b1;
      cyc(); cyc();
      chk("bne_n_pcsrc", PCSrc, 2'b00);
      chk("bne_n_pcwre", PCWre, 1);
      cyc();
      chk("bne_n_cnt", InstRetired, 4);

      // BGTZ: ZERO=1 not taken, then ZERO=0 taken within the same cycle
      Op = 6'b000111; SIGN = 1'b0; ZERO = 1'b1;
      cyc(); cyc();
      chk("bgtz_z_pcsrc", PCSrc, 2'b00);
      ZERO = 1'b0;
      #1 chk("bgtz_t_pcsrc", PCSrc, 2'b01);
      SIGN = 1'b1;
      #1 chk("bgtz_s_pcsrc", PCSrc, 2'b00);
      cyc();
      chk("bgtz_cnt", InstRetired, 5);

      // BEQ taken
      Op = 6'b000100; ZERO = 1'b1; SIGN = 1'b0;
      cyc(); cyc();
      chk("beq_t_pcsrc", PCSrc, 2'b01);
      cyc();
      chk("beq_cnt", InstRetired, 6);

      // JAL
      Op = 6'b000011;
      cyc();
      chk("jal_regwr", RegWr, 1);
      chk("jal_regdst", RegDst, 2'b00);
      chk("jal_wrsrc", WrDataSrc, 2'b10);
      chk("jal_pcsrc", PCSrc, 2'b10);
      chk("jal_pcwre", PCWre, 1);
      cyc();
      chk("jal_back_irwre", IRWre, 1);
      chk("jal_cnt", InstRetired, 7);

      // JR
      Op = 6'b000000; Func = 6'b001000;
      cyc();
      chk("jr_pcsrc", PCSrc, 2'b11);
      chk("jr_pcwre", PCWre, 1);
      chk("jr_regwr", RegWr, 0);
      cyc();
      chk("jr_cnt", InstRetired, 8);

      // Illegal opcode, then illegal R-type func
      Op = 6'b111110;
      cyc();
      chk("ill_op_flag", IllegalOp, 1);
      chk("ill_op_pcwre", PCWre, 1);
      chk("ill_op_pcsrc", PCSrc, 2'b00);
      cyc();
      chk("ill_op_pulse", IllegalOp, 0);
      chk("ill_op_cnt", InstRetired, 9);
      Op = 6'b000000; Func = 6'b111111;
      cyc();
      chk("ill_fn_flag", IllegalOp, 1);
      cyc();
      chk("ill_fn_cnt", InstRetired, 10);

      // SW with ready memory
      Op = 6'b101011;
      cyc(); cyc();
      chk("sw_exe_srcb", ALUSrcB, 1);
      cyc();
      chk("sw_mem_nwr", nWR, 0);
      chk("sw_mem_pcwre", PCWre, 1);
      cyc();
      chk("sw_cnt", InstRetired, 11);

      // SW interrupted by reset while stalled in sMEM
      cyc(); cyc();
      MemReady = 1'b0;
      cyc();
      chk("swr_mem_nwr", nWR, 0);
      nRST = 1'b0;
      #1 chk("swr_inrst_nwr", nWR, 1);
      cyc();
      chk("swr_after_nwr", nWR, 1);
      chk("swr_after_cnt", InstRetired, 0);
      nRST = 1'b1; MemReady = 1'b1;
      #1 chk("swr_if_irwre", IRWre, 1);

      // Sixteen J instructions wrap the 4-bit counter
      Op = 6'b000010;
      for (int i = 0; i < 16; i++) begin
         cyc();
         cyc();
         if (i == 14) chk("wrap_15", InstRetired, 15);
         if (i == 15) chk("wrap_0", InstRetired, 0);
      end

      // HALT is absorbing until reset
      Op = 6'b111111;
      cyc();
      chk("halt_id_pcwre", PCWre, 0);
      chk("halt_id_halted", Halted, 0);
      cyc();
      for (int i = 0; i < 20; i++) begin
         chk("halt_halted", Halted, 1);
         chk("halt_pcwre", PCWre, 0);
         MemReady = ~MemReady;
         cyc();
      end
      chk("halt_cnt", InstRetired, 0);
      MemReady = 1'b1;
      nRST = 1'b0;
      #1 chk("halt_rst_halted", Halted, 0);
      cyc();
      nRST = 1'b1;
      #1 chk("halt_rst_cnt", InstRetired, 0);
      chk("halt_rst_irwre", IRWre, 1);
      cyc();
      chk("halt_rst_id", Halted, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
